// File: rtl/bmp_stream_parser_if.sv
`default_nettype none
// ============================================================================
// Module      : bmp_stream_parser_if
// Description : Bundles the byte-stream input, the pixel valid/ready output
//               and the header/status outputs of bmp_stream_parser.
//               The parser connects through the slave modport. The byte
//               source and pixel consumer connect through the master modport.
//   i_Rx_DV / i_Rx_Byte   : byte strobe and value
//   o_Pix_Valid/i_Pix_Ready: pixel handshake
//   o_Pix_Data/X/Y/Last   : pixel {R,G,B}, coordinates, end of frame
//   o_Width/o_Height      : latched header dimensions
//   o_Hdr_Valid           : header accepted
//   o_Frame_Done          : one-cycle frame-complete pulse
//   o_Err                 : sticky errors [0] magic [1] format [2] overflow
// Revision    : 1.0 - initial release
// ============================================================================
interface bmp_stream_parser_if;
  logic        i_Rx_DV;
  logic [7:0]  i_Rx_Byte;
  logic        o_Pix_Valid;
  logic        i_Pix_Ready;
  logic [23:0] o_Pix_Data;
  logic [15:0] o_Pix_X;
  logic [15:0] o_Pix_Y;
  logic        o_Pix_Last;
  logic [15:0] o_Width;
  logic [15:0] o_Height;
  logic        o_Hdr_Valid;
  logic        o_Frame_Done;
  logic [2:0]  o_Err;

  modport slave (
    input  i_Rx_DV, i_Rx_Byte, i_Pix_Ready,
    output o_Pix_Valid, o_Pix_Data, o_Pix_X, o_Pix_Y, o_Pix_Last,
    output o_Width, o_Height, o_Hdr_Valid, o_Frame_Done, o_Err
  );

  modport master (
    output i_Rx_DV, i_Rx_Byte, i_Pix_Ready,
    input  o_Pix_Valid, o_Pix_Data, o_Pix_X, o_Pix_Y, o_Pix_Last,
    input  o_Width, o_Height, o_Hdr_Valid, o_Frame_Done, o_Err
  );
endinterface
`default_nettype wire

// File: rtl/bmp_stream_parser.sv
`default_nettype none
// ============================================================================
// Module      : bmp_stream_parser
// Description : Parses a 24-bit uncompressed BMP file arriving one byte per
//               strobe. Validates the header, skips to the pixel array,
//               strips row padding and queues {R,G,B} pixels with X/Y
//               coordinates in a small valid/ready FIFO.
// Ports       : i_Clock   - system clock
//               i_Reset_n - synchronous active-low reset
//               bus       - bmp_stream_parser_if.slave (byte input, pixel
//                           output, header dimensions, status and errors)
// Revision    : 1.0 - initial release
// ============================================================================
module bmp_stream_parser #(
  parameter int FIFO_DEPTH = 4
) (
  input wire                 i_Clock,
  input wire                 i_Reset_n,
  bmp_stream_parser_if.slave bus
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = 57;  // {R,G,B}=24, X=16, Y=16, last=1
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_SKIP = 3'd1,
    S_PIX  = 3'd2,
    S_PAD  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     bc_q, bc_d;
  logic [31:0]     offset_q, offset_d;
  logic [31:0]     width_q, width_d;
  logic [31:0]     height_q, height_d;
  logic [15:0]     bpp_q, bpp_d;
  logic            hdr_valid_q, hdr_valid_d;
  logic [2:0]      err_q, err_d;
  logic [1:0]      phase_q, phase_d;
  logic [7:0]      blue_q, blue_d;
  logic [7:0]      green_q, green_d;
  logic [15:0]     x_q, x_d;
  logic [15:0]     y_q, y_d;
  logic [1:0]      pad_cnt_q, pad_cnt_d;
  logic            last_row_q, last_row_d;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [EW-1:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            fifo_empty;
  logic            fifo_full;
  logic            pop;
  logic            row_end;
  logic            last_y;
  logic            fmt_ok;
  logic            push_req;
  logic            push_ok;
  logic [EW-1:0]   push_entry;
  logic            frame_done;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == C_FULL);
  assign pop        = !fifo_empty && bus.i_Pix_Ready;
  assign row_end    = (x_q == width_q[15:0] - 16'd1);
  assign last_y     = (y_q == height_q[15:0] - 16'd1);

  // All latched fields are complete by the time byte 53 is strobed.
  assign fmt_ok = (bpp_q == 16'd24)
               && (width_q[31:16] == 16'd0) && (width_q[15:0] != 16'd0)
               && (height_q[31:16] == 16'd0) && (height_q[15:0] != 16'd0)
               && (offset_q[31:16] == 16'd0) && (offset_q[15:0] >= 16'd54);

  always_comb begin
    state_d     = state_q;
    bc_d        = bc_q;
    offset_d    = offset_q;
    width_d     = width_q;
    height_d    = height_q;
    bpp_d       = bpp_q;
    hdr_valid_d = hdr_valid_q;
    err_d       = err_q;
    phase_d     = phase_q;
    blue_d      = blue_q;
    green_d     = green_q;
    x_d         = x_q;
    y_d         = y_q;
    pad_cnt_d   = pad_cnt_q;
    last_row_d  = last_row_q;
    mem_d       = mem_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    push_req    = 1'b0;
    push_ok     = 1'b0;
    frame_done  = 1'b0;
    push_entry  = {bus.i_Rx_Byte, green_q, blue_q, x_q, y_q, row_end && last_y};

    case (state_q)
      S_HDR: begin
        if (bus.i_Rx_DV) begin
          bc_d = bc_q + 16'd1;
          case (bc_q)
            16'd10:  offset_d[7:0]   = bus.i_Rx_Byte;
            16'd11:  offset_d[15:8]  = bus.i_Rx_Byte;
            16'd12:  offset_d[23:16] = bus.i_Rx_Byte;
            16'd13:  offset_d[31:24] = bus.i_Rx_Byte;
            16'd18:  width_d[7:0]    = bus.i_Rx_Byte;
            16'd19:  width_d[15:8]   = bus.i_Rx_Byte;
            16'd20:  width_d[23:16]  = bus.i_Rx_Byte;
            16'd21:  width_d[31:24]  = bus.i_Rx_Byte;
            16'd22:  height_d[7:0]   = bus.i_Rx_Byte;
            16'd23:  height_d[15:8]  = bus.i_Rx_Byte;
            16'd24:  height_d[23:16] = bus.i_Rx_Byte;
            16'd25:  height_d[31:24] = bus.i_Rx_Byte;
            16'd28:  bpp_d[7:0]      = bus.i_Rx_Byte;
            16'd29:  bpp_d[15:8]     = bus.i_Rx_Byte;
            default: begin end
          endcase
          if (((bc_q == 16'd0) && (bus.i_Rx_Byte != 8'h42)) ||
              ((bc_q == 16'd1) && (bus.i_Rx_Byte != 8'h4D))) begin
            err_d[0] = 1'b1;
            state_d  = S_ERR;
          end else if (bc_q == 16'd53) begin
            if (fmt_ok) begin
              hdr_valid_d = 1'b1;
              x_d         = 16'd0;
              y_d         = 16'd0;
              phase_d     = 2'd0;
              state_d     = (offset_q[15:0] > 16'd54) ? S_SKIP : S_PIX;
            end else begin
              err_d[1] = 1'b1;
              state_d  = S_ERR;
            end
          end
        end
      end

      S_SKIP: begin
        if (bus.i_Rx_DV) begin
          bc_d = bc_q + 16'd1;
          if (bc_q == offset_q[15:0] - 16'd1) begin
            state_d = S_PIX;
          end
        end
      end

      S_PIX: begin
        if (bus.i_Rx_DV) begin
          bc_d = bc_q + 16'd1;
          case (phase_q)
            2'd0: begin
              blue_d  = bus.i_Rx_Byte;
              phase_d = 2'd1;
            end
            2'd1: begin
              green_d = bus.i_Rx_Byte;
              phase_d = 2'd2;
            end
            default: begin
              phase_d  = 2'd0;
              push_req = 1'b1;
              if (row_end) begin
                x_d = 16'd0;
                y_d = y_q + 16'd1;
                // 24-bit rows pad to a 4-byte boundary: 3*w mod 4 pad bytes
                // needed equals w mod 4.
                if (width_q[1:0] != 2'd0) begin
                  pad_cnt_d  = width_q[1:0];
                  last_row_d = last_y;
                  state_d    = S_PAD;
                end else if (last_y) begin
                  state_d = S_DONE;
                end
              end else begin
                x_d = x_q + 16'd1;
              end
            end
          endcase
        end
      end

      S_PAD: begin
        if (bus.i_Rx_DV) begin
          bc_d      = bc_q + 16'd1;
          pad_cnt_d = pad_cnt_q - 2'd1;
          if (pad_cnt_q == 2'd1) begin
            state_d = last_row_q ? S_DONE : S_PIX;
          end
        end
      end

      S_DONE: begin
        if (fifo_empty) begin
          frame_done  = 1'b1;
          hdr_valid_d = 1'b0;
          bc_d        = 16'd0;
          state_d     = S_HDR;
        end
      end

      S_ERR: begin
      end

      default: begin
        state_d = S_HDR;
      end
    endcase

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok = push_req && (!fifo_full || pop);
    if (push_req && fifo_full && !pop) begin
      err_d[2] = 1'b1;
    end
    if (push_ok) begin
      mem_d[wptr_q] = push_entry;
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: begin end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state_q     <= S_HDR;
      bc_q        <= '0;
      offset_q    <= '0;
      width_q     <= '0;
      height_q    <= '0;
      bpp_q       <= '0;
      hdr_valid_q <= 1'b0;
      err_q       <= '0;
      phase_q     <= '0;
      blue_q      <= '0;
      green_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      pad_cnt_q   <= '0;
      last_row_q  <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      bc_q        <= bc_d;
      offset_q    <= offset_d;
      width_q     <= width_d;
      height_q    <= height_d;
      bpp_q       <= bpp_d;
      hdr_valid_q <= hdr_valid_d;
      err_q       <= err_d;
      phase_q     <= phase_d;
      blue_q      <= blue_d;
      green_q     <= green_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pad_cnt_q   <= pad_cnt_d;
      last_row_q  <= last_row_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign bus.o_Pix_Valid  = !fifo_empty;
  assign {bus.o_Pix_Data, bus.o_Pix_X, bus.o_Pix_Y, bus.o_Pix_Last} = mem_q[rptr_q];
  assign bus.o_Width      = width_q[15:0];
  assign bus.o_Height     = height_q[15:0];
  assign bus.o_Hdr_Valid  = hdr_valid_q;
  assign bus.o_Frame_Done = frame_done;
  assign bus.o_Err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bmp_stream_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_bmp_stream_parser
// Description : Scoreboard bench for bmp_stream_parser. Builds BMP files from
//               randomized fields, predicts the pixel stream from the BMP
//               layout rules, and checks popped pixels in a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bmp_stream_parser;
  localparam int FIFO_DEPTH = 4;

  typedef struct {
    logic [23:0] d;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] w;
    logic [15:0] h;
    logic        last;
    logic        fd;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  logic fd_pending = 1'b0;
  int   rdy_mode   = 0;
  int   gap_max    = 0;
  bit   seq_pix    = 1'b0;

  always #5 clk = ~clk;

  bmp_stream_parser_if bus();

  bmp_stream_parser #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .i_Clock   (clk),
    .i_Reset_n (rst_n),
    .bus       (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands over a pixel.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.o_Frame_Done === 1'b1) begin
        check("frame_done_after_last_pop", 64'(fd_pending), 64'd1);
        fd_pending = 1'b0;
      end
      if (bus.o_Pix_Valid === 1'b1 && bus.i_Pix_Ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pixel: got %h at (%0d,%0d) required none",
                   bus.o_Pix_Data, bus.o_Pix_X, bus.o_Pix_Y);
        end else begin
          e = exp_q.pop_front();
          check("pix_data",   64'(bus.o_Pix_Data), 64'(e.d));
          check("pix_x",      64'(bus.o_Pix_X),    64'(e.x));
          check("pix_y",      64'(bus.o_Pix_Y),    64'(e.y));
          check("pix_last",   64'(bus.o_Pix_Last), 64'(e.last));
          check("hdr_width",  64'(bus.o_Width),    64'(e.w));
          check("hdr_height", 64'(bus.o_Height),   64'(e.h));
          if (e.fd) fd_pending = 1'b1;
        end
      end
    end
  end

  initial begin : ready_drv
    bus.i_Pix_Ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.i_Pix_Ready = 1'b1;
        1:       bus.i_Pix_Ready = ($urandom_range(3) != 0);
        default: bus.i_Pix_Ready = 1'b0;
      endcase
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(gap_max)) tick();
    bus.i_Rx_DV   = 1'b1;
    bus.i_Rx_Byte = b;
    tick();
    bus.i_Rx_DV   = 1'b0;
  endtask

  // Builds a BMP file, predicts its pixels, and sends it (or its first
  // 'cut' bytes). At most 'keep' pixels are expected to reach the output.
  task automatic run_file(input int w, input int h, input int off, input int bpp,
                          input logic [7:0] m0, input int cut, input int keep);
    logic [7:0]  hdr [54];
    logic [7:0]  bq[$];
    exp_t        loc[$];
    exp_t        e;
    logic [31:0] v;
    logic [7:0]  b, g, r;
    int          pad, sv, k, n, pos;
    bit          good;
    for (int i = 0; i < 54; i++) hdr[i] = 8'($urandom);
    hdr[0] = m0;
    hdr[1] = 8'h4D;
    v = 32'(off); {hdr[13], hdr[12], hdr[11], hdr[10]} = v;
    v = 32'(w);   {hdr[21], hdr[20], hdr[19], hdr[18]} = v;
    v = 32'(h);   {hdr[25], hdr[24], hdr[23], hdr[22]} = v;
    v = 32'(bpp); {hdr[29], hdr[28]} = v[15:0];
    for (int i = 0; i < 54; i++) bq.push_back(hdr[i]);
    for (int i = 54; i < off; i++) bq.push_back(8'($urandom));
    good = (m0 == 8'h42) && (bpp == 24) && (w > 0) && (h > 0) && (w < 65536)
        && (h < 65536) && (off >= 54);
    pad = (4 - ((3 * w) % 4)) % 4;
    sv  = 1;
    k   = 0;
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        b = seq_pix ? 8'(sv)     : 8'($urandom);
        g = seq_pix ? 8'(sv + 1) : 8'($urandom);
        r = seq_pix ? 8'(sv + 2) : 8'($urandom);
        sv += 3;
        bq.push_back(b); bq.push_back(g); bq.push_back(r);
        pos = bq.size() - 1;
        if (good && k < keep && (cut == 0 || pos < cut)) begin
          e.d = {r, g, b}; e.x = 16'(xx); e.y = 16'(yy);
          e.w = 16'(w);    e.h = 16'(h);
          e.last = (xx == w - 1) && (yy == h - 1);
          e.fd   = 1'b0;
          loc.push_back(e);
          k++;
        end
      end
      for (int p = 0; p < pad; p++) bq.push_back(8'hEE);
    end
    if (cut == 0 && loc.size() > 0) loc[loc.size() - 1].fd = 1'b1;
    foreach (loc[i]) exp_q.push_back(loc[i]);

    n = (cut == 0) ? bq.size() : cut;
    for (int i = 0; i < n; i++) begin
      send_byte(bq[i]);
      if (i == 0 && m0 != 8'h42) begin
        check("err_bad_magic", 64'(bus.o_Err), 64'd1);
        check("hdr_valid_bad_magic", 64'(bus.o_Hdr_Valid), 64'd0);
      end
      if (i == 53) begin
        check("hdr_valid_at_53", 64'(bus.o_Hdr_Valid), 64'(good));
        if (good) begin
          check("width_at_53",  64'(bus.o_Width),  64'(w));
          check("height_at_53", 64'(bus.o_Height), 64'(h));
        end else begin
          check("err_at_53", 64'(bus.o_Err), (m0 != 8'h42) ? 64'd1 : 64'd2);
        end
      end
    end
  endtask

  task automatic drain(input bit expect_hdr_clear);
    for (int i = 0; i < 3000 && (exp_q.size() != 0 || fd_pending); i++) tick();
    check("drain_remaining", 64'(exp_q.size()) + 64'(fd_pending), 64'd0);
    if (expect_hdr_clear) check("hdr_valid_cleared", 64'(bus.o_Hdr_Valid), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"},  64'(bus.o_Pix_Valid),  64'd0);
    check({tag, "_data"},   64'(bus.o_Pix_Data),   64'd0);
    check({tag, "_x"},      64'(bus.o_Pix_X),      64'd0);
    check({tag, "_y"},      64'(bus.o_Pix_Y),      64'd0);
    check({tag, "_last"},   64'(bus.o_Pix_Last),   64'd0);
    check({tag, "_width"},  64'(bus.o_Width),      64'd0);
    check({tag, "_height"}, 64'(bus.o_Height),     64'd0);
    check({tag, "_hdr"},    64'(bus.o_Hdr_Valid),  64'd0);
    check({tag, "_fdone"},  64'(bus.o_Frame_Done), 64'd0);
    check({tag, "_err"},    64'(bus.o_Err),        64'd0);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin : driver
    bus.i_Rx_DV   = 1'b0;
    bus.i_Rx_Byte = 8'h00;
    rst_n = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // 2x2, rows padded by 2 bytes, sequential pixel bytes 01..0C.
    seq_pix = 1'b1;
    run_file(2, 2, 54, 24, 8'h42, 0, 1000);
    drain(1'b1);
    seq_pix = 1'b0;

    // Width 4 (no padding), 4 filler bytes before the pixel array.
    run_file(4, 1, 58, 24, 8'h42, 0, 1000);
    drain(1'b1);

    // Randomized files with throttled consumer and byte gaps.
    rdy_mode = 1;
    gap_max  = 2;
    for (int t = 0; t < 8; t++) begin
      run_file($urandom_range(6, 1), $urandom_range(3, 1), 54 + $urandom_range(6),
               24, 8'h42, 0, 1000);
      drain(1'b1);
    end
    gap_max = 0;

    // Consumer stalled: 6 pixels into a 4-deep FIFO.
    rdy_mode = 2;
    repeat (2) tick();
    run_file(3, 2, 54, 24, 8'h42, 0, FIFO_DEPTH);
    repeat (2) tick();
    check("overflow_err", 64'(bus.o_Err), 64'd4);
    check("overflow_valid", 64'(bus.o_Pix_Valid), 64'd1);
    rdy_mode = 0;
    drain(1'b1);
    check("overflow_err_sticky", 64'(bus.o_Err), 64'd4);
    reset_pulse();
    check_zero("after_ovf_reset");

    // Bad magic byte.
    run_file(2, 2, 54, 24, 8'h41, 0, 1000);
    repeat (3) tick();
    check("bad_magic_err_final", 64'(bus.o_Err), 64'd1);
    check("bad_magic_hdr_final", 64'(bus.o_Hdr_Valid), 64'd0);
    drain(1'b0);
    reset_pulse();

    // Unsupported bit depth.
    run_file(2, 2, 54, 32, 8'h42, 0, 1000);
    repeat (3) tick();
    check("bad_bpp_err_final", 64'(bus.o_Err), 64'd2);
    check("bad_bpp_hdr_final", 64'(bus.o_Hdr_Valid), 64'd0);
    drain(1'b0);
    reset_pulse();

    // Reset in the middle of a pixel row, then a fresh 1x1 file.
    run_file(3, 2, 54, 24, 8'h42, 54 + 12 + 1, 1000);
    drain(1'b0);
    reset_pulse();
    check_zero("mid_frame_reset");
    run_file(1, 1, 54, 24, 8'h42, 0, 1000);
    drain(1'b1);
    check("single_pixel_err", 64'(bus.o_Err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bmp_stream_parser.md
# bmp_stream_parser

Consumes the received-byte stream (one strobe per byte) on the image-upload path and parses a 24-bit uncompressed BMP file. It validates the header, extracts width, height and pixel-data offset, skips to the pixel array, strips row padding, and emits BGR triplets as {R,G,B} pixels. Pixels are emitted with X/Y coordinates through a small valid/ready FIFO to the image-processing core. Sticky error flags cover malformed files and FIFO overflow.

## Interface
- FIFO_DEPTH, 4: pixel output FIFO entries (power of 2, ≥2)
- i_Clock  in  1  system clock
- i_Reset_n  in  1  synchronous active-low reset
- i_Rx_DV  in  1  byte strobe, one cycle per byte, synchronous to i_Clock
- i_Rx_Byte  in  8  byte value, valid when i_Rx_DV=1
- o_Pix_Valid  out  1  FIFO head valid
- i_Pix_Ready  in  1  consumer accepts head when both high
- o_Pix_Data  out  24  {R,G,B}
- o_Pix_X  out  16  column, 0..width-1
- o_Pix_Y  out  16  row in arrival order, 0 = first (bottom) row
- o_Pix_Last  out  1  final pixel of frame
- o_Width, o_Height  out  16 each  latched header dims
- o_Hdr_Valid  out  1  header accepted, dims valid
- o_Frame_Done  out  1  one-cycle pulse, frame complete
- o_Err  out  3  sticky: [0] bad magic, [1] unsupported format, [2] pixel overflow

## Operation
- Byte counter BC (16 bit) counts accepted bytes from file start; advances only on i_Rx_DV.
- States: S_HDR, S_SKIP, S_PIX, S_PAD, S_DONE, S_ERR.
- S_HDR: bytes 0..53. Checks: byte0=0x42, byte1=0x4D; otherwise set o_Err[0] and go to S_ERR on that byte. Little-endian latches: offset = bytes 10..13, width = 18..21, height = 22..25, bpp = 28..29.
- On byte 53, the format check requires all of: bpp=24; width and height nonzero with upper 16 bits zero; offset[31:16]=0; offset≥54. On fail, set o_Err[1] and go to S_ERR. On pass, go to S_SKIP if offset>54, else S_PIX.
- S_SKIP: discard bytes until BC=offset-1 is consumed, then go to S_PIX.
- S_PIX: byte phase 0/1/2 = B/G/R. The third byte pushes {R,G,B,X,Y,last} into the FIFO; X increments.
  - At X=width-1: X←0. Go to S_PAD if width[1:0]≠0, with pad count = width[1:0]. Otherwise the row is finished.
  - Row finish: Y increments. If Y=height-1, the pixel is last and the state goes to S_DONE.
- S_PAD: discard width[1:0] bytes, then go to S_PIX, or to S_DONE if the last row finished.
- S_DONE: waits for the FIFO to be empty, then pulses o_Frame_Done, clears o_Hdr_Valid, and returns to S_HDR. Bytes arriving in S_DONE are discarded.
- S_ERR: absorbs all bytes; no pixels pushed; exit only by reset.
- FIFO overflow: a push while full with no same-cycle pop drops the new pixel and sets o_Err[2]. Parsing continues, X/Y still advance, and the state does not change.
- Push and pop in the same cycle while full is legal; no overflow.

## Timing
- Reset value of every output is 0; the FIFO is emptied and the state returns to S_HDR. Reset mid-frame discards all progress.
- A byte is consumed in the cycle i_Rx_DV=1. Parser state, counters and latches update at that edge.
- o_Hdr_Valid rises 1 cycle after byte 53 is strobed (format pass). It holds until o_Frame_Done or reset.
- Pixel latency: o_Pix_Valid is high 1 cycle after the R-byte strobe when the FIFO was empty.
- A pop occurs on the edge where o_Pix_Valid & i_Pix_Ready. Outputs are stable while o_Pix_Valid=1 and i_Pix_Ready=0.
- o_Frame_Done asserts in the cycle after the last pixel is popped (FIFO empty in S_DONE).
- o_Err bits are set 1 cycle after the offending byte and clear only on reset.

## Test plan
- 2×2 image, offset 54, rows padded by 2 bytes, pixel bytes 01..0C plus pad, ready=1 → four pixels:
  - 030201 @(0,0)
  - 060504 @(1,0)
  - 090807 @(0,1)
  - 0C0B0A @(1,1) with Last=1
  - o_Frame_Done pulse follows the final pop; pad bytes never appear.
- Width 4 (no pad), height 1, offset 58 (4 filler bytes) → filler skipped; 4 pixels; X = 0..3, Y = 0.
- First byte 0x41 → o_Err=001 next cycle; no pixels for the remaining stream; o_Hdr_Valid stays 0.
- bpp=32 in otherwise valid header → o_Err=010 after byte 53; o_Hdr_Valid stays 0.
- FIFO_DEPTH=4, i_Pix_Ready=0, 6 pixels sent → 4 buffered, o_Err[2]=1. Then ready=1 → the first 4 pixels pop in order with correct coordinates.
- Assert i_Reset_n=0 for 1 cycle mid-pixel-row, then send a fresh valid 1×1 file → all outputs 0 after reset; single pixel at (0,0) with Last=1; o_Err=000.
